// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: the instruction-memory handshake, the decoder-facing
// instruction outputs, and the stall/branch controls coming back from the decoder.
interface inst_fetch_if #(
  parameter int PC_W = 8
);
  logic            stall;
  logic            branch_take;
  logic [PC_W-1:0] branch_target;
  logic            mem_req;
  logic [PC_W-1:0] mem_addr;
  logic            mem_ack;
  logic [7:0]      mem_rdata;
  logic [7:0]      inst;
  logic            isim4;
  logic [PC_W-1:0] inst_pc;
  logic            inst_valid;
  logic            halted;

  modport master (
    input  stall, branch_take, branch_target, mem_ack, mem_rdata,
    output mem_req, mem_addr, inst, isim4, inst_pc, inst_valid, halted
  );

  modport slave (
    output stall, branch_take, branch_target, mem_ack, mem_rdata,
    input  mem_req, mem_addr, inst, isim4, inst_pc, inst_valid, halted
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC, memory req/ack handshake, registered inst to decoder.
// Define INST_FETCH_HALT_EN to stop fetching after a HALT_OP instruction is consumed.
module inst_fetch #(
  parameter int              PC_W       = 8,
  parameter logic [PC_W-1:0] RESET_PC   = '0,
  parameter logic [15:0]     ISIM4_MASK = 16'h0F00
`ifdef INST_FETCH_HALT_EN
  ,
  parameter logic [3:0]      HALT_OP    = 4'hF
`endif
) (
  input  logic         clk,
  input  logic         rst,
  inst_fetch_if.master bus
);

`ifdef INST_FETCH_HALT_EN
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_DRAIN, S_HALTED} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_DRAIN} state_t;
`endif

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] drain_q, drain_d;
  logic [7:0]      inst_q, inst_d;
  logic            isim4_q, isim4_d;
  logic [PC_W-1:0] ipc_q, ipc_d;
  logic            valid_q, valid_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      drain_q <= RESET_PC;
      inst_q  <= 8'h00;
      isim4_q <= 1'b0;
      ipc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drain_q <= drain_d;
      inst_q  <= inst_d;
      isim4_q <= isim4_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drain_d = drain_q;
    inst_d  = inst_q;
    isim4_d = isim4_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        if (bus.branch_take) begin
          pc_d    = bus.branch_target;
          valid_d = 1'b0;
        end
      end
      S_FETCH: begin
        if (bus.branch_take) begin
          pc_d    = bus.branch_target;
          valid_d = 1'b0;
          // Unacked request must complete at its old address before redirecting.
          if (!bus.mem_ack) begin
            drain_d = pc_q;
            state_d = S_DRAIN;
          end
        end else if (bus.mem_ack) begin
          inst_d  = bus.mem_rdata;
          isim4_d = ISIM4_MASK[bus.mem_rdata[7:4]];
          ipc_d   = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_q + PC_W'(1);
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.branch_take) begin
          pc_d    = bus.branch_target;
          valid_d = 1'b0;
          state_d = S_FETCH;
        end else if (!bus.stall) begin
          valid_d = 1'b0;
`ifdef INST_FETCH_HALT_EN
          state_d = (inst_q[7:4] == HALT_OP) ? S_HALTED : S_FETCH;
`else
          state_d = S_FETCH;
`endif
        end
      end
      S_DRAIN: begin
        if (bus.branch_take) pc_d = bus.branch_target;
        if (bus.mem_ack) state_d = S_FETCH;
      end
`ifdef INST_FETCH_HALT_EN
      S_HALTED: begin
        if (bus.branch_take) begin
          pc_d    = bus.branch_target;
          state_d = S_FETCH;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.mem_req    = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign bus.mem_addr   = (state_q == S_DRAIN) ? drain_q : pc_q;
  assign bus.inst       = inst_q;
  assign bus.isim4      = isim4_q;
  assign bus.inst_pc    = ipc_q;
  assign bus.inst_valid = valid_q;
`ifdef INST_FETCH_HALT_EN
  assign bus.halted     = (state_q == S_HALTED);
`else
  assign bus.halted     = 1'b0;
`endif

endmodule
